bp_lite_to_burst: RTL

Upstream counterpart of the burst-to-lite stage. It accepts one BedRock Lite message (header plus full-width data) and emits it as a BedRock Burst stream: one header on the header channel and N narrow data beats on the data channel. It sits between a wide Lite producer (cache/IO engine) and the wormhole burst network, whose far end reassembles the message.

---
 rtl/bp_lite_to_burst_pkg.sv | 41 ++++
 rtl/bp_me_piso_dynamic.sv | 59 +++++
 rtl/bp_lite_to_burst.sv | 91 +++++++++
 3 files changed

// File: rtl/bp_lite_to_burst_pkg.sv
// Shared BedRock definitions for the Lite-to-Burst converter: message header
// layout, message type and size encodings.
package bp_lite_to_burst_pkg;

  localparam int paddr_width_lp   = 40;
  localparam int payload_width_lp = 16;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bedrock_msg_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bedrock_msg_size_e;

  typedef struct packed {
    logic [payload_width_lp-1:0] payload;
    bedrock_msg_size_e           size;
    logic [paddr_width_lp-1:0]   addr;
    bedrock_msg_e                msg_type;
  } bedrock_header_s;

  localparam int header_width_lp = $bits(bedrock_header_s);

  function automatic int unsigned size_bytes(bedrock_msg_size_e size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/bp_me_piso_dynamic.sv
// Parallel-in/serial-out with a run-time beat count; emits the least
// significant out_width_p slice first.
module bp_me_piso_dynamic #(
  parameter  int in_width_p   = 512,
  parameter  int out_width_p  = 64,
  localparam int cnt_width_lp = $clog2(in_width_p / out_width_p) + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [in_width_p-1:0]   data_i,
  input  logic [cnt_width_lp-1:0] len_i,
  input  logic                    v_i,
  output logic                    ready_and_o,
  output logic [out_width_p-1:0]  data_o,
  output logic                    v_o,
  input  logic                    ready_and_i
);

  logic [in_width_p-1:0]   r_data;
  logic [cnt_width_lp-1:0] r_cnt;
  logic                    r_pending;
  logic                    w_fire_in;
  logic                    w_fire_out;
  logic                    w_last;

  assign ready_and_o = reset_n_i & ~r_pending;
  assign v_o         = r_pending;
  assign data_o      = r_data[32'(r_cnt) * out_width_p +: out_width_p];
  assign w_fire_in   = v_i & ready_and_o;
  assign w_fire_out  = r_pending & ready_and_i;
  assign w_last      = (r_cnt == len_i - cnt_width_lp'(1));

  // NOTE: the data register has no reset; it is only observed while r_pending is set.
  always_ff @(posedge clk_i) begin
    if (w_fire_in) r_data <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_pending <= 1'b0;
      r_cnt     <= '0;
    end else if (w_fire_in) begin
      r_pending <= 1'b1;
      r_cnt     <= '0;
    end else if (w_fire_out) begin
      if (w_last) begin
        r_pending <= 1'b0;
        r_cnt     <= '0;
      end else begin
        r_cnt <= r_cnt + cnt_width_lp'(1);
      end
    end
  end

  a_hold_until_handshake: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (v_o && !ready_and_i) |=> (v_o && $stable(data_o)));

endmodule

// File: rtl/bp_lite_to_burst.sv
// Converts one wide BedRock Lite message ({header, data}) into a Burst stream:
// one header on the header channel plus num_beats narrow data beats.
module bp_lite_to_burst
  import bp_lite_to_burst_pkg::*;
#(
  parameter  int          in_data_width_p         = 512,
  parameter  int          out_data_width_p        = 64,
  parameter  logic [15:0] payload_mask_p          = '0,
  localparam int          in_msg_width_lp         = header_width_lp + in_data_width_p,
  localparam int          out_msg_header_width_lp = header_width_lp
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [in_msg_width_lp-1:0]         in_msg_i,
  input  logic                               in_msg_v_i,
  output logic                               in_msg_ready_and_o,
  output logic [out_msg_header_width_lp-1:0] out_msg_header_o,
  output logic                               out_msg_header_v_o,
  input  logic                               out_msg_header_ready_and_i,
  output logic [out_data_width_p-1:0]        out_msg_data_o,
  output logic                               out_msg_data_v_o,
  input  logic                               out_msg_data_ready_and_i
);

  localparam int cnt_width_lp = $clog2(in_data_width_p / out_data_width_p) + 1;
  localparam int out_bytes_lp = out_data_width_p / 8;
  localparam int in_bytes_lp  = in_data_width_p / 8;

  if (in_data_width_p <= out_data_width_p || (in_data_width_p % out_data_width_p) != 0) begin : g_bad_width
    $error("in_data_width_p must be a wider integer multiple of out_data_width_p");
  end

  bedrock_header_s             w_in_header;
  bedrock_header_s             r_header;
  logic [in_data_width_p-1:0]  w_in_data;
  logic                        r_header_pending;
  logic                        w_accept;
  logic                        w_has_data;
  logic                        w_piso_ready;
  logic [cnt_width_lp-1:0]     w_num_beats;

  assign w_in_header        = in_msg_i[in_msg_width_lp-1 -: header_width_lp];
  assign w_in_data          = in_msg_i[in_data_width_p-1:0];
  assign w_has_data         = payload_mask_p[w_in_header.msg_type];
  assign in_msg_ready_and_o = w_piso_ready & ~r_header_pending;
  assign w_accept           = in_msg_v_i & in_msg_ready_and_o;

  assign out_msg_header_o   = r_header;
  assign out_msg_header_v_o = r_header_pending;

  always_ff @(posedge clk_i) begin
    if (w_accept) r_header <= w_in_header;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                      r_header_pending <= 1'b0;
    else if (w_accept)                   r_header_pending <= 1'b1;
    else if (out_msg_header_ready_and_i) r_header_pending <= 1'b0;
  end

  // NOTE: every always_comb output is written on every path, so no latch is inferred.
  always_comb begin
    int unsigned beats;
    beats = size_bytes(r_header.size) / out_bytes_lp;
    if (beats == 0) beats = 1;
    w_num_beats = cnt_width_lp'(beats);
  end

  bp_me_piso_dynamic #(
    .in_width_p  (in_data_width_p),
    .out_width_p (out_data_width_p)
  ) u_piso (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .data_i      (w_in_data),
    .len_i       (w_num_beats),
    .v_i         (w_accept & w_has_data),
    .ready_and_o (w_piso_ready),
    .data_o      (out_msg_data_o),
    .v_o         (out_msg_data_v_o),
    .ready_and_i (out_msg_data_ready_and_i)
  );

  a_size_fits: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (w_accept && w_has_data) |-> (size_bytes(w_in_header.size) <= in_bytes_lp));

  a_header_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (out_msg_header_v_o && !out_msg_header_ready_and_i) |=>
      (out_msg_header_v_o && $stable(out_msg_header_o)));

endmodule
